// File: rtl/zigma_dmem_responder.sv
// Zigma RV32I data-memory responder: LSU request/response handshake, LATENCY wait states, byte/half/word access.
// Optional ZIGMA_DMEM_BACK2BACK_EN lets a new request be accepted in the response-handshake cycle.
module zigma_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        alive_q;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, do_access, from_req;
  logic        a_we;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_f3;
  logic [IDX_W-1:0] idx;
  logic        f3_ok, misaligned, in_range, acc_err;
  logic [31:0] rd_word, load_val, wlanes;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;

`ifdef ZIGMA_DMEM_BACK2BACK_EN
  assign req_ready = alive_q && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
`else
  assign req_ready = alive_q && (state_q == ST_IDLE);
`endif

  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero latency the access happens on the acceptance edge, so it must use the live request.
  assign from_req  = (state_q != ST_WAIT);
  assign a_we      = from_req ? req_we     : we_q;
  assign a_addr    = from_req ? req_addr   : addr_q;
  assign a_wdata   = from_req ? req_wdata  : wdata_q;
  assign a_f3      = from_req ? req_funct3 : funct3_q;
  assign do_access = (accept && (LAT_CNT == 4'd0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  assign idx        = a_addr[IDX_W+1:2];
  assign in_range   = {2'b00, a_addr[31:2]} < DEPTH_WORDS;
  assign f3_ok      = a_we ? (a_f3 <= 3'd2) : (a_f3 != 3'd3 && a_f3 != 3'd6 && a_f3 != 3'd7);
  assign misaligned = ((a_f3[1:0] == 2'd1) && a_addr[0]) || ((a_f3[1:0] == 2'd2) && (a_addr[1:0] != 2'd0));
  assign acc_err    = !f3_ok || misaligned || !in_range;

  assign rd_word = mem[idx];
  assign byte_v  = rd_word[{a_addr[1:0], 3'b000} +: 8];
  assign half_v  = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    load_val = 32'd0;
    wlanes   = a_wdata;
    be       = 4'b0000;
    case (a_f3)
      3'd0:    load_val = {{24{byte_v[7]}}, byte_v};
      3'd1:    load_val = {{16{half_v[15]}}, half_v};
      3'd2:    load_val = rd_word;
      3'd4:    load_val = {24'd0, byte_v};
      3'd5:    load_val = {16'd0, half_v};
      default: load_val = 32'd0;
    endcase
    case (a_f3)
      3'd0:    wlanes = {4{a_wdata[7:0]}};
      3'd1:    wlanes = {2{a_wdata[15:0]}};
      default: wlanes = a_wdata;
    endcase
    if (do_access && a_we && !acc_err) begin
      case (a_f3)
        3'd0:    be[a_addr[1:0]] = 1'b1;
        3'd1:    be = a_addr[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    if (do_access) begin
      rdata_d = (a_we || acc_err) ? 32'd0 : load_val;
      err_d   = acc_err;
    end

    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Acceptance happens in IDLE, or in RESP alongside the handshake when back-to-back is enabled.
    if (accept) begin
      we_d     = req_we;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      funct3_d = req_funct3;
      cnt_d    = LAT_CNT;
      state_d  = (LAT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      alive_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alive_q  <= 1'b1;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; it maps onto plain RAM with byte enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_zigma_dmem_responder.sv
// Scoreboard bench for zigma_dmem_responder: directed loads/stores, errors, stall, mid-op reset, throughput.
module tb_zigma_dmem_responder;

  localparam int LAT0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic        b_req_valid = 1'b1, b_rsp_ready = 1'b1;

  zigma_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Zero-latency instance streaming stores, used only for throughput.
  zigma_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b1),
    .req_addr(32'h0000_0040), .req_wdata(32'h0BAD_F00D), .req_funct3(3'd2),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   cyc = 0, hs_count = 0, b_hs = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each response once, on its first visible cycle; count handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rdata %h err %b with empty scoreboard", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc_cyc), 32'(LAT0 + 1));
        end
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        hs_count++;
      end
    end
  end

  always @(negedge clk) if (b_rsp_valid && b_rsp_ready) b_hs++;

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input bit exp_err,
                       input bit track);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end else if (track) begin
      sb.push_back('{rdata: exp_rd, err: exp_err, acc_cyc: cyc + 1});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || rsp_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout: pending %0d rsp_valid %b", sb.size(), rsp_valid);
      sb.delete();
    end
  endtask

  task automatic op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, input logic [31:0] exp_rd, input bit exp_err);
    issue(we, addr, wdata, f3, exp_rd, exp_err, 1'b1);
    wait_done();
  endtask

  initial begin
    int hs0, n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Basic word, byte and half traffic.
    op(1, 32'h0000_0000, 32'h1111_2222, 3'd2, 32'h0, 0);
    op(1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2, 32'h0, 0);
    op(0, 32'h0000_0010, 32'h0,         3'd2, 32'hDEAD_BEEF, 0);
    op(1, 32'h0000_0013, 32'h0000_0080, 3'd0, 32'h0, 0);
    op(0, 32'h0000_0013, 32'h0,         3'd0, 32'hFFFF_FF80, 0);
    op(0, 32'h0000_0013, 32'h0,         3'd4, 32'h0000_0080, 0);
    op(0, 32'h0000_0010, 32'h0,         3'd2, 32'h80AD_BEEF, 0);
    op(0, 32'h0000_0012, 32'h0,         3'd1, 32'hFFFF_80AD, 0);
    op(0, 32'h0000_0012, 32'h0,         3'd5, 32'h0000_80AD, 0);
    op(0, 32'h0000_0010, 32'h0,         3'd0, 32'hFFFF_FFEF, 0);
    op(0, 32'h0000_0011, 32'h0,         3'd4, 32'h0000_00BE, 0);
    op(1, 32'h0000_0014, 32'h0,         3'd2, 32'h0, 0);
    op(1, 32'h0000_0016, 32'hFFFF_5678, 3'd1, 32'h0, 0);
    op(0, 32'h0000_0014, 32'h0,         3'd2, 32'h5678_0000, 0);
    op(1, 32'h0000_03FC, 32'hA5A5_A5A5, 3'd2, 32'h0, 0);
    op(0, 32'h0000_03FC, 32'h0,         3'd2, 32'hA5A5_A5A5, 0);

    // Error cases, then confirm storage untouched.
    op(0, 32'h0000_0011, 32'h0,         3'd1, 32'h0, 1);
    op(0, 32'h0000_0012, 32'h0,         3'd2, 32'h0, 1);
    op(1, 32'h0000_0400, 32'hCAFE_F00D, 3'd2, 32'h0, 1);
    op(0, 32'h0000_0000, 32'h0,         3'd2, 32'h1111_2222, 0);
    op(0, 32'h0000_0010, 32'h0,         3'd3, 32'h0, 1);
    op(1, 32'h0000_0010, 32'h0000_0000, 3'd4, 32'h0, 1);

    // Response stall: outputs hold, no new request accepted, exactly one handshake on release.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(0, 32'h0000_0010, 32'h0, 3'd2, 32'h80AD_BEEF, 0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'h80AD_BEEF);
      check("stall_rsp_err", 32'(rsp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_handshakes", 32'(hs_count - hs0), 32'd1);

    // Reset during WAIT aborts an uncommitted store.
    op(1, 32'h0000_0020, 32'h0, 3'd2, 32'h0, 0);
    hs0 = hs_count;
    issue(1, 32'h0000_0020, 32'h1234_5678, 3'd2, 32'h0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("abort_no_handshake", 32'(hs_count - hs0), 32'd0);
    op(0, 32'h0000_0020, 32'h0, 3'd2, 32'h0, 0);

    // Throughput of the zero-latency instance with req_valid and rsp_ready held high.
    @(negedge clk);
    hs0 = b_hs;
    repeat (20) @(negedge clk);
`ifdef ZIGMA_DMEM_BACK2BACK_EN
    check("throughput_20cyc", 32'(b_hs - hs0), 32'd20);
`else
    check("throughput_20cyc", 32'(b_hs - hs0), 32'd10);
`endif
    check("fast_rsp_err", 32'(b_rsp_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
